// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared instruction/data memory port: the CPU wins by default,
// and a starvation counter forces a loader grant after STARVE_LIMIT consecutive CPU grants.
module mem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 8,
    parameter int MAX_WAIT     = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              err_clr,
    output logic              timeout_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_owner;          // 0 = CPU, 1 = loader
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [3:0]          r_starve_cnt;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_ldr_rdata;
    logic                r_timeout_err;

    logic                w_grant_any;
    logic                w_grant_ldr;
    logic                w_abort;

    assign w_grant_any = cpu_req | ldr_req;
    assign w_grant_ldr = ldr_req & (~cpu_req | (r_starve_cnt == 4'(STARVE_LIMIT)));
    // The final wait cycle is the one in which the counter would reach MAX_WAIT.
    assign w_abort     = ~mem_ready & (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_any) w_state_next = S_ACCESS;
            S_ACCESS: if (mem_ready || w_abort) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_read  = (r_state == S_ACCESS) & ~r_we;
        mem_write = (r_state == S_ACCESS) &  r_we;
        cpu_done  = (r_state == S_DONE)   & ~r_owner;
        ldr_done  = (r_state == S_DONE)   &  r_owner;
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign cpu_rdata   = r_cpu_rdata;
    assign ldr_rdata   = r_ldr_rdata;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner       <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wait_cnt    <= '0;
            r_starve_cnt  <= '0;
            r_cpu_rdata   <= '0;
            r_ldr_rdata   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_grant_any) begin
                    r_owner    <= w_grant_ldr;
                    r_we       <= w_grant_ldr ? ldr_we    : cpu_we;
                    r_addr     <= w_grant_ldr ? ldr_addr  : cpu_addr;
                    r_wdata    <= w_grant_ldr ? ldr_wdata : cpu_wdata;
                    r_wait_cnt <= '0;
                end
                if (!ldr_req || w_grant_ldr)
                    r_starve_cnt <= '0;
                else if (cpu_req && (r_starve_cnt < 4'(STARVE_LIMIT)))
                    r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            if (r_state == S_ACCESS) begin
                if (mem_ready) begin
                    if (!r_we && !r_owner) r_cpu_rdata <= mem_rdata;
                    if (!r_we &&  r_owner) r_ldr_rdata <= mem_rdata;
                end else begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    if (w_abort && !r_we && !r_owner) r_cpu_rdata <= '0;
                    if (w_abort && !r_we &&  r_owner) r_ldr_rdata <= '0;
                end
            end

            // An abort in the same cycle as err_clr keeps the flag set.
            if ((r_state == S_ACCESS) && w_abort) r_timeout_err <= 1'b1;
            else if (err_clr)                     r_timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: each task pushes the transactions it expects,
// and a negedge monitor pops and checks them as done pulses appear.
module tb_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_done;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       ldr_req, ldr_we, ldr_done;
    logic [4:0] ldr_addr;
    logic [7:0] ldr_wdata, ldr_rdata;
    logic       mem_read, mem_write, mem_ready, err_clr, timeout_err;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] tb_mem [32];
    assign mem_rdata = tb_mem[mem_addr];

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_WAIT(15), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err_clr(err_clr), .timeout_err(timeout_err)
    );

    typedef struct {
        bit         port;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        int         cycles;
        logic [7:0] cpu_rd;
        logic [7:0] ldr_rd;
        bit         err;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_cpu_rd, m_ldr_rd;
    int         ready_at = 1;
    bit         idle_ready = 1'b0;
    int         acc_cnt = 0;
    int         str_cnt = 0;
    logic [4:0] s_addr;
    logic       s_we;
    logic [7:0] s_wdata;

    function automatic void push_exp(bit port, bit we, logic [4:0] addr, logic [7:0] wd, int rdy, bit err);
        exp_t       e;
        logic [7:0] rd;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wd;
        e.cycles = (rdy == 0) ? 15 : rdy;
        if (!we) begin
            rd = (rdy == 0) ? 8'h00 : tb_mem[addr];
            if (port) m_ldr_rd = rd; else m_cpu_rd = rd;
        end
        e.cpu_rd = m_cpu_rd; e.ldr_rd = m_ldr_rd; e.err = err;
        sb.push_back(e);
    endfunction

    // Memory responder: raises mem_ready on the ready_at-th strobe cycle (0 = never).
    always @(negedge clock) begin
        if (mem_read || mem_write) begin
            acc_cnt++;
            mem_ready = (ready_at != 0) && (acc_cnt == ready_at);
        end else begin
            acc_cnt   = 0;
            mem_ready = idle_ready;
        end
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            str_cnt = 0;
        end else begin
            if (mem_read || mem_write) begin
                str_cnt++;
                s_addr = mem_addr; s_we = mem_write; s_wdata = mem_wdata;
                checks++;
                if (mem_read && mem_write) begin
                    errors++; $display("FAIL strobe_excl: read=%0b write=%0b, required not both", mem_read, mem_write);
                end
            end
            if (cpu_done || ldr_done) begin
                checks++;
                if (sb.size() == 0 || (cpu_done && ldr_done)) begin
                    errors++;
                    $display("FAIL unexpected_done: cpu_done=%0b ldr_done=%0b queued=%0d", cpu_done, ldr_done, sb.size());
                end else begin
                    e = sb.pop_front();
                    $display("XACT %s we=%0b addr=%h wdata=%h strobes=%0d cpu_rdata=%h ldr_rdata=%h err=%0b",
                             ldr_done ? "LDR" : "CPU", s_we, s_addr, s_wdata, str_cnt, cpu_rdata, ldr_rdata, timeout_err);
                    if (ldr_done !== e.port) begin
                        errors++; $display("FAIL done_port: ldr_done=%0b, required %0b", ldr_done, e.port);
                    end
                    checks++;
                    if (str_cnt != e.cycles) begin
                        errors++; $display("FAIL strobe_cycles: got %0d, required %0d", str_cnt, e.cycles);
                    end
                    checks++;
                    if (s_addr !== e.addr || s_we !== e.we) begin
                        errors++; $display("FAIL mem_addr_we: got %h/%0b, required %h/%0b", s_addr, s_we, e.addr, e.we);
                    end
                    if (e.we) begin
                        checks++;
                        if (s_wdata !== e.wdata) begin
                            errors++; $display("FAIL mem_wdata: got %h, required %h", s_wdata, e.wdata);
                        end
                    end
                    checks++;
                    if (cpu_rdata !== e.cpu_rd || ldr_rdata !== e.ldr_rd) begin
                        errors++;
                        $display("FAIL rdata: cpu %h ldr %h, required cpu %h ldr %h", cpu_rdata, ldr_rdata, e.cpu_rd, e.ldr_rd);
                    end
                    checks++;
                    if (timeout_err !== e.err) begin
                        errors++; $display("FAIL done_err: timeout_err=%0b, required %0b", timeout_err, e.err);
                    end
                end
                str_cnt = 0;
            end
        end
    end

    task automatic xact(input bit port, input bit we, input logic [4:0] addr, input logic [7:0] wd,
                        input int rdy, input bit err, input string name);
        int n = 0;
        int exp_lat = 1 + ((rdy == 0) ? 15 : rdy);
        ready_at = rdy;
        push_exp(port, we, addr, wd, rdy, err);
        if (port) begin ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd; end
        else      begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (port ? ldr_done : cpu_done) begin n = i; break; end
        end
        checks++;
        if (n != exp_lat) begin
            errors++; $display("FAIL %s_latency: done after %0d cycles, required %0d", name, n, exp_lat);
        end
        if (n == 0) sb.delete();
        cpu_req = 0; ldr_req = 0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; err_clr = 0; mem_ready = 0;
        for (int i = 0; i < 32; i++) tb_mem[i] = 8'(i * 29 + 7);
        tb_mem[10] = 8'h3C;
        m_cpu_rd = 0; m_ldr_rd = 0;
        repeat (2) @(negedge clock);
        checks++;
        if ({mem_read, mem_write, cpu_done, ldr_done, timeout_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: rd/wr/cdone/ldone/err=%b, required 00000",
                               {mem_read, mem_write, cpu_done, ldr_done, timeout_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, ldr_rdata} !== 29'b0) begin
            errors++; $display("FAIL reset_data: addr=%h wdata=%h crd=%h lrd=%h, required all 0",
                               mem_addr, mem_wdata, cpu_rdata, ldr_rdata);
        end
        reset = 1;
        @(negedge clock);
    endtask

    task automatic test_single_read();
        xact(0, 0, 5'h0A, 8'h00, 1, 0, "single_read");
    endtask

    task automatic test_write_waits();
        idle_ready = 1;
        xact(1, 1, 5'h1F, 8'hA5, 4, 0, "write_waits");
        idle_ready = 0;
    endtask

    task automatic test_contention();
        int cnt = 0;
        ready_at = 1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) push_exp(1, 0, 5'h09, 8'h00, 1, 0);
            else        push_exp(0, 0, 5'h03, 8'h00, 1, 0);
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
        ldr_req = 1; ldr_we = 0; ldr_addr = 5'h09;
        for (int i = 0; i < 80 && cnt < 6; i++) begin
            @(negedge clock);
            if (cpu_done || ldr_done) begin
                cnt++;
                if (cnt == 4 || cnt == 5) begin
                    checks++;
                    if (dut.r_starve_cnt !== ((cnt == 4) ? 4'd4 : 4'd0)) begin
                        errors++; $display("FAIL starve_cnt: at done %0d got %0d, required %0d",
                                           cnt, dut.r_starve_cnt, (cnt == 4) ? 4 : 0);
                    end
                end
            end
        end
        cpu_req = 0; ldr_req = 0;
        checks++;
        if (cnt != 6) begin
            errors++; $display("FAIL contention_count: %0d dones, required 6", cnt);
        end
        if (cnt != 6) sb.delete();
        @(negedge clock);
    endtask

    task automatic test_cancel();
        int n = 0;
        ready_at = 3;
        push_exp(0, 0, 5'h05, 8'h00, 3, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h05;
        @(negedge clock);
        cpu_req = 0; cpu_addr = 5'h11; cpu_we = 1;
        for (int i = 2; i <= 30; i++) begin
            @(negedge clock);
            if (cpu_done) begin n = i; break; end
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL cancel_done: done after %0d cycles, required 4", n);
        end
        if (n == 0) sb.delete();
        cpu_we = 0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int n1 = 0;
        int n2 = 0;
        ready_at = 1;
        push_exp(0, 0, 5'h02, 8'h00, 1, 0);
        push_exp(0, 0, 5'h14, 8'h00, 1, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h02;
        @(negedge clock);
        cpu_addr = 5'h14;
        for (int i = 2; i <= 30; i++) begin
            @(negedge clock);
            if (cpu_done && n1 == 0) n1 = i;
            else if (cpu_done) begin n2 = i; break; end
        end
        cpu_req = 0;
        checks++;
        if (n1 != 2 || n2 != 5) begin
            errors++; $display("FAIL back_to_back: dones at %0d,%0d, required 2,5", n1, n2);
        end
        if (n2 == 0) sb.delete();
        @(negedge clock);
    endtask

    task automatic test_timeout();
        int k = 0;
        bit got = 0;
        xact(0, 0, 5'h06, 8'h00, 0, 1, "timeout");
        repeat (3) @(negedge clock);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: timeout_err=%0b, required 1", timeout_err);
        end
        err_clr = 1;
        @(negedge clock);
        err_clr = 0;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL err_clear: timeout_err=%0b, required 0", timeout_err);
        end
        ready_at = 0;
        push_exp(0, 0, 5'h07, 8'h00, 0, 1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h07;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (mem_read) k++;
            err_clr = (k == 15) && mem_read;
            if (cpu_done) begin got = 1; break; end
        end
        cpu_req = 0; err_clr = 0;
        checks++;
        if (!got) begin
            errors++; $display("FAIL set_vs_clear_done: no cpu_done, required one"); sb.delete();
        end
        @(negedge clock);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL set_vs_clear: timeout_err=%0b, required 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        ready_at = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'h08;
        repeat (2) @(negedge clock);
        reset = 0;
        #1;
        checks++;
        if (mem_read !== 1'b0 || cpu_done !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_mid: mem_read=%0b cpu_done=%0b err=%0b, required 0/0/0",
                               mem_read, cpu_done, timeout_err);
        end
        cpu_req = 0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (cpu_done !== 1'b0) begin
                errors++; $display("FAIL reset_no_done: cpu_done=%0b, required 0", cpu_done);
            end
        end
        reset = 1; m_cpu_rd = 0; m_ldr_rd = 0;
        @(negedge clock);
        xact(0, 0, 5'h0C, 8'h00, 1, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_waits();
        test_contention();
        test_cancel();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_left: %0d entries, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 8-bit instruction/data memory port between the CPU sequencer and a program-loader/debug port. Each requester uses a request/done handshake. The arbiter latches the winning request, drives the memory strobes, waits on `mem_ready` with a timeout, and returns read data. It sits between the CPU's memory strobes (`mem_read`/`mem_write`) and the memory array. The CPU has default priority; a starvation counter guarantees loader progress.

## Interface
- `ADDR_W`, 5, address width (matches the 5-bit operand field of the 8-bit instruction)
- `DATA_W`, 8, data width
- `MAX_WAIT`, 15, number of ACCESS cycles without `mem_ready` before abort (1..255)
- `STARVE_LIMIT`, 4, number of consecutive CPU grants while the loader is pending before the loader is forced to win (1..15)

- `clock` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low; all state cleared while low
- `cpu_req` in 1: CPU access request, level, held until `cpu_done`
- `cpu_we` in 1: 1 = write, 0 = read
- `cpu_addr` in ADDR_W: CPU address
- `cpu_wdata` in DATA_W: CPU write data
- `cpu_done` out 1: one-cycle completion pulse
- `cpu_rdata` out DATA_W: read data, valid while `cpu_done` = 1, held afterward
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_done`, `ldr_rdata`: loader port, same directions, widths and semantics as the CPU port
- `mem_read` out 1: memory read strobe
- `mem_write` out 1: memory write strobe
- `mem_addr` out ADDR_W: latched address
- `mem_wdata` out DATA_W: latched write data
- `mem_rdata` in DATA_W: memory read data, sampled when `mem_ready` = 1
- `mem_ready` in 1: memory completes the current access this cycle
- `err_clr` in 1: synchronous clear of `timeout_err`
- `timeout_err` out 1: sticky flag, set on any aborted access

## Operation
- **State machine:** IDLE, ACCESS, DONE. Reset state is IDLE.
- **IDLE:**
  - Samples `cpu_req` and `ldr_req`.
  - Only one high: that port wins.
  - Both high: the CPU wins unless `starve_cnt == STARVE_LIMIT`, in which case the loader wins.
  - On a win, latches `owner`, `we`, `addr` and `wdata` from the winner, clears `wait_cnt`, and moves to ACCESS.
  - Neither high: stays in IDLE.
- **starve_cnt:**
  - Increments, saturating at STARVE_LIMIT, on each CPU grant made while `ldr_req` = 1.
  - Clears on any loader grant.
  - Clears on any IDLE cycle where `ldr_req` = 0.
- **ACCESS:**
  - Drives `mem_read = ~we` and `mem_write = we`. `mem_addr`/`mem_wdata` come from the latched values.
  - `mem_ready` = 1: capture `mem_rdata` into the owner's rdata register (reads only; writes leave it unchanged), then go to DONE.
  - `mem_ready` = 0: increment `wait_cnt`. When `wait_cnt` reaches MAX_WAIT, abort: set `timeout_err`, load the owner's rdata with 0 (reads only), then go to DONE.
- **DONE:**
  - Asserts the owner's done output.
  - Strobes are low.
  - Unconditionally returns to IDLE.
- **Request changes mid-transaction:** changes on `req`/`we`/`addr`/`wdata` after the grant are ignored. Dropping `req` during ACCESS does not cancel the transaction; it completes and `done` still pulses.
- **Requester obligation:** drop `req` by the clock edge that ends the done cycle. If `req` is still high in IDLE, it is treated as a new back-to-back transaction.
- **err_clr vs. abort:** `err_clr` clears `timeout_err`. If a set and a clear occur in the same cycle, the set wins.
- **Width rules:** `wait_cnt` is $clog2(MAX_WAIT+1) bits. `starve_cnt` is 4 bits.

## Timing
- **Reset values:**
  - State = IDLE.
  - `mem_read`, `mem_write`, `cpu_done`, `ldr_done`, `timeout_err` = 0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `ldr_rdata` = 0.
  - `starve_cnt`, `wait_cnt` = 0.
- **Outputs:** all registered or decoded from state only. No combinational path from `req` to strobes or `done`.
- **Zero-wait latency:** `req` is sampled at edge E0. Strobes are high in cycle E0–E1. `mem_ready` is sampled at E1. `done` is high in cycle E1–E2. IDLE is re-entered at E2.
  - Request to `done`: 2 cycles.
  - Maximum throughput: 1 access per 3 cycles.
- **N wait states:** `done` asserts N cycles later.
- **Timeout:** strobes stay high for exactly MAX_WAIT cycles, then `done` asserts with `timeout_err` = 1 in the same cycle.
- **mem_ready outside ACCESS:** ignored.
- **Reset mid-ACCESS:** strobes drop immediately (asynchronous). No `done` is issued. The pending requester must re-request after reset.

## Test plan
- **Single CPU read:** `cpu_req`=1, `cpu_addr`=5'h0A, `cpu_we`=0, `mem_ready` tied 1, `mem_rdata`=8'h3C -> `mem_read` high for exactly 1 cycle with `mem_addr`=0A; `cpu_done` one cycle later with `cpu_rdata`=3C; `ldr_done` stays 0.
- **Write with waits:** loader writes 8'hA5 to addr 5'h1F, `mem_ready` high on the 4th ACCESS cycle -> `mem_write` high for 4 cycles with `mem_wdata`=A5; `ldr_done` pulses once; `ldr_rdata` unchanged.
- **Contention/starvation:** both requests held high continuously with `STARVE_LIMIT`=4 -> grant order CPU, CPU, CPU, CPU, LDR, CPU, ...; `starve_cnt` returns to 0 after the loader grant.
- **Timeout:** CPU read, `mem_ready` held 0 -> `mem_read` high for 15 cycles, `cpu_done` pulses with `cpu_rdata`=0 and `timeout_err`=1; the flag stays set until `err_clr`=1 for one cycle; a simultaneous abort and `err_clr` leaves it 1.
- **Reset mid-access:** `reset` low during the 2nd wait cycle -> `mem_read` 0 asynchronously, no `done`; after release, a fresh CPU read completes normally in 2 cycles.
- **Cancel/back-to-back:** `cpu_req` dropped during ACCESS -> `cpu_done` still pulses; `cpu_req` held through DONE -> second access starts on the next IDLE cycle.
